// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared loader states, character classes and the ASCII-to-digit decode function
package sudoku_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    typedef struct packed {
        logic       valid;
        logic       is_empty;
        logic       is_sep;
        logic [4:0] value;
    } dec_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_BAR   = 8'h7c;
    localparam logic [7:0] CH_DASH  = 8'h2d;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_DOT   = 8'h2e;

    function automatic dec_t char_to_digit(input logic [7:0] c, input int side);
        dec_t d;
        d = '0;
        if (c inside {CH_SPACE, CH_CR, CH_LF, CH_COMMA, CH_BAR, CH_DASH}) begin
            d.valid  = 1'b1;
            d.is_sep = 1'b1;
        end else if (c inside {CH_ZERO, CH_DOT}) begin
            d.valid    = 1'b1;
            d.is_empty = 1'b1;
        end else begin
            if (c inside {[8'h31:8'h39]})
                d.value = 5'(c - 8'h30);
            else if (c inside {[8'h41:8'h47]})
                d.value = 5'(c - 8'h37);
            else if (c inside {[8'h61:8'h67]})
                d.value = 5'(c - 8'h57);
            // letters decode on every board size; the range check rejects them when the board is too small
            d.valid = d.value != 5'd0 && int'(d.value) <= side;
        end
        return d;
    endfunction

endpackage

// File: rtl/sudoku_char_decoder.sv
// sudoku_char_decoder: combinational ASCII classifier for a board of p_SIDE digits
module sudoku_char_decoder
    import sudoku_pkg::*;
#(
    parameter int p_SIDE = 9
) (
    input  logic [7:0] i_Byte,
    output dec_t       o_Dec
);

    assign o_Dec = char_to_digit(i_Byte, p_SIDE);

endmodule

// File: rtl/sudoku_grid_loader.sv
// sudoku_grid_loader: UART byte stream to one-hot candidate grid; SUDOKU_LOADER_CONFLICT_CHECK_EN adds clue-conflict detection
module sudoku_grid_loader
    import sudoku_pkg::*;
#(
    parameter int p_BOX = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Rx_Valid,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Grid_Valid,
    output logic       o_Error,
    output logic [7:0] o_Err_Cell,
    output logic [p_BOX-1:0][p_BOX-1:0][p_BOX-1:0][p_BOX-1:0][p_BOX*p_BOX-1:0] o_Grid
);

    localparam int p_SIDE = p_BOX * p_BOX;
    localparam int CW     = $clog2(p_SIDE);
    localparam int BW     = $clog2(p_BOX);

    typedef logic [p_BOX-1:0][p_BOX-1:0][p_BOX-1:0][p_BOX-1:0][p_SIDE-1:0] grid_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    grid_t           grid_q, grid_d;
    logic [7:0]      err_cell_q, err_cell_d;
    logic            done_q, done_d;
    dec_t            dec;
    logic [BW-1:0]   br, bc, cr, cc;
    logic [p_SIDE-1:0] digit_oh;
    logic [7:0]      cell_idx;
    logic            last_col, last_row, conflict;

    sudoku_char_decoder #(.p_SIDE(p_SIDE)) u_dec (
        .i_Byte (i_Rx_Byte),
        .o_Dec  (dec)
    );

    assign br       = BW'(row_q / CW'(p_BOX));
    assign bc       = BW'(col_q / CW'(p_BOX));
    assign cr       = BW'(row_q % CW'(p_BOX));
    assign cc       = BW'(col_q % CW'(p_BOX));
    assign digit_oh = p_SIDE'(1) << (dec.value - 5'd1);
    assign cell_idx = 8'(int'(row_q) * p_SIDE + int'(col_q));
    assign last_col = col_q == CW'(p_SIDE - 1);
    assign last_row = row_q == CW'(p_SIDE - 1);

`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
    logic [p_SIDE-1:0][p_SIDE-1:0] row_used_q, row_used_d, col_used_q, col_used_d, box_used_q, box_used_d;
    logic [CW-1:0] box_idx;
    assign box_idx  = CW'(int'(br) * p_BOX + int'(bc));
    assign conflict = |((row_used_q[row_q] | col_used_q[col_q] | box_used_q[box_idx]) & digit_oh);
`else
    assign conflict = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        grid_d     = grid_q;
        err_cell_d = err_cell_q;
        done_d     = 1'b0;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
        row_used_d = row_used_q;
        col_used_d = col_used_q;
        box_used_d = box_used_q;
`endif
        // a start pulse wins over any byte arriving in the same cycle
        if (i_Start) begin
            state_d    = LOAD;
            row_d      = '0;
            col_d      = '0;
            grid_d     = '0;
            err_cell_d = '0;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
            row_used_d = '0;
            col_used_d = '0;
            box_used_d = '0;
`endif
        end else if (state_q == LOAD && i_Rx_Valid && !dec.is_sep) begin
            if (!dec.valid || conflict) begin
                state_d    = ERROR;
                err_cell_d = cell_idx;
            end else begin
                if (!dec.is_empty) begin
                    grid_d[br][bc][cr][cc] = digit_oh;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
                    row_used_d[row_q]   = row_used_q[row_q] | digit_oh;
                    col_used_d[col_q]   = col_used_q[col_q] | digit_oh;
                    box_used_d[box_idx] = box_used_q[box_idx] | digit_oh;
`endif
                end
                col_d = last_col ? '0 : CW'(col_q + 1'b1);
                row_d = last_col ? (last_row ? '0 : CW'(row_q + 1'b1)) : row_q;
                if (last_col && last_row) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            grid_q     <= '0;
            err_cell_q <= '0;
            done_q     <= 1'b0;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
            row_used_q <= '0;
            col_used_q <= '0;
            box_used_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            grid_q     <= grid_d;
            err_cell_q <= err_cell_d;
            done_q     <= done_d;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
            row_used_q <= row_used_d;
            col_used_q <= col_used_d;
            box_used_q <= box_used_d;
`endif
        end
    end

    assign o_Busy       = state_q == LOAD;
    assign o_Grid_Valid = state_q == DONE;
    assign o_Error      = state_q == ERROR;
    assign o_Done       = done_q;
    assign o_Err_Cell   = err_cell_q;
    assign o_Grid       = grid_q;

endmodule

// File: tb/tb_sudoku_grid_loader.sv
// tb_sudoku_grid_loader: directed and randomized byte streams checked against a cell-level board model
module tb_sudoku_grid_loader;

    logic clk = 1'b0;
    logic rst, start3, valid3, start4, valid4;
    logic [7:0] byte3, byte4;
    logic busy3, done3, gv3, err3, busy4, done4, gv4, err4;
    logic [7:0] ec3, ec4;
    logic [2:0][2:0][2:0][2:0][8:0]   grid3;
    logic [3:0][3:0][3:0][3:0][15:0]  grid4;

    always #5 clk = ~clk;

    sudoku_grid_loader #(.p_BOX(3)) dut3 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start3), .i_Rx_Valid(valid3), .i_Rx_Byte(byte3),
        .o_Busy(busy3), .o_Done(done3), .o_Grid_Valid(gv3), .o_Error(err3), .o_Err_Cell(ec3), .o_Grid(grid3)
    );

    sudoku_grid_loader #(.p_BOX(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start4), .i_Rx_Valid(valid4), .i_Rx_Byte(byte4),
        .o_Busy(busy4), .o_Done(done4), .o_Grid_Valid(gv4), .o_Error(err4), .o_Err_Cell(ec4), .o_Grid(grid4)
    );

    int checks = 0, errors = 0;
    int m_state, m_idx, m_err_cell, m_done_exp;
    int m_cells[81];
    int done_seen = 0, done4_seen = 0;

    always @(negedge clk) begin
        if (done3) done_seen++;
        if (done4) done4_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 = separator, 1 = cell (v = 0 for empty), 2 = invalid
    function automatic int dec_model(input logic [7:0] c, input int side, output int v);
        string seps = " \015\012,|-";
        string up   = "123456789ABCDEFG";
        string lo   = "123456789abcdefg";
        v = 0;
        for (int i = 0; i < seps.len(); i++) if (c == seps[i]) return 0;
        if (c == "0" || c == ".") return 1;
        for (int i = 0; i < side; i++)
            if (c == up[i] || c == lo[i]) begin
                v = i + 1;
                return 1;
            end
        return 2;
    endfunction

    function automatic bit conflict_model(input int idx, input int v);
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
        if (v != 0)
            for (int j = 0; j < 81; j++)
                if (m_cells[j] == v && (j / 9 == idx / 9 || j % 9 == idx % 9 ||
                    (j / 27 == idx / 27 && (j % 9) / 3 == (idx % 9) / 3)))
                    return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int pattern(input int idx);
        return ((idx / 9) * 3 + idx / 27 + idx % 9) % 9 + 1;
    endfunction

    function automatic logic [8:0] g3(input int i);
        return grid3[2'(i / 27)][2'((i % 9) / 3)][2'((i / 9) % 3)][2'(i % 3)];
    endfunction

    function automatic logic [31:0] onehot(input int v);
        return v == 0 ? 32'd0 : 32'd1 << (v - 1);
    endfunction

    task automatic send(input logic [7:0] c);
        bit dn;
        int k, v;
        dn = 1'b0;
        if (m_state == 1) begin
            k = dec_model(c, 9, v);
            if (k == 2 || (k == 1 && conflict_model(m_idx, v))) begin
                m_state = 3;
                m_err_cell = m_idx;
            end else if (k == 1) begin
                m_cells[m_idx] = v;
                m_idx++;
                if (m_idx == 81) begin
                    m_state = 2;
                    dn = 1'b1;
                    m_done_exp++;
                end
            end
        end
        byte3 = c;
        valid3 = 1'b1;
        @(negedge clk);
        valid3 = 1'b0;
        check("done_pulse", done3, dn);
        check("busy", busy3, m_state == 1);
        check("error", err3, m_state == 3);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic model_clear();
        m_idx = 0;
        m_err_cell = 0;
        foreach (m_cells[i]) m_cells[i] = 0;
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] c);
        model_clear();
        m_state = 1;
        start3 = 1'b1;
        valid3 = with_byte;
        byte3 = c;
        @(negedge clk);
        start3 = 1'b0;
        valid3 = 1'b0;
        check("start_busy", busy3, 1'b1);
    endtask

    task automatic do_reset();
        model_clear();
        m_state = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_stream(input int n, input int mode, input bit bad);
        string seps = " \015\012,|-";
        string bads = "X@zH#A";
        int p;
        logic [7:0] c;
        for (int i = 0; i < n && m_state == 1; i++) begin
            p = int'($urandom_range(99));
            if (bad && p < 3) c = bads[$urandom_range(bads.len() - 1)];
            else if (p < 18) c = seps[$urandom_range(seps.len() - 1)];
            else if (p < 45) c = p[0] ? "0" : ".";
            else c = 8'(8'h30 + (mode == 0 ? pattern(m_idx) : int'($urandom_range(1, 9))));
            send(c);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        for (int i = 0; i < 81; i++) check($sformatf("%s_cell%0d", tag, i), g3(i), onehot(m_cells[i]));
        check({tag, "_grid_valid"}, gv3, m_state == 2);
        check({tag, "_error"}, err3, m_state == 3);
        check({tag, "_busy"}, busy3, m_state == 1);
        check({tag, "_done"}, done3, 1'b0);
        check({tag, "_done_count"}, done_seen, m_done_exp);
        if (m_state == 3 || m_state == 0) check({tag, "_err_cell"}, ec3, m_err_cell);
    endtask

    initial begin
        int base;
        rst = 1'b1; start3 = 1'b0; valid3 = 1'b0; byte3 = 8'h0;
        start4 = 1'b0; valid4 = 1'b0; byte4 = 8'h0;
        m_done_exp = 0;
        model_clear();
        m_state = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_grid3_zero", 32'(|grid3), 0);
        check("rst_grid4_zero", 32'(|grid4), 0);
        check("rst_err_cell", ec3, 8'd0);
        check_all("reset");

        // directed board from the example stream
        do_start(1'b0, 8'h0);
        send_str("53..7....\015\012");
        for (int r = 1; r < 8; r++) send_str(".........\015\012");
        send_str(".........");
        check("cell00_5", grid3[0][0][0][0], 9'b000010000);
        check("cell01_3", grid3[0][0][0][1], 9'b000000100);
        check("cell04_7", grid3[0][1][0][1], 9'b001000000);
        send_str("\015\0127");
        check_all("directed");

        // invalid character at cell 40
        do_start(1'b0, 8'h0);
        for (int i = 0; i < 40; i++) send(i % 3 == 0 ? 8'h2e : 8'(8'h30 + pattern(i)));
        send("X");
        check("x_err_cell", ec3, 8'd40);
        send_str("123.");
        check_all("bad_x");

        // letter digit out of range for a 9x9 board
        do_start(1'b0, 8'h0);
        send("A");
        check("a_err_cell", ec3, 8'd0);
        check_all("bad_a");

        // restart mid-load with a colliding byte that must be dropped
        do_start(1'b0, 8'h0);
        rand_stream(20, 0, 1'b0);
        base = done_seen;
        do_start(1'b1, "9");
        for (int k = 0; k < 400 && m_state == 1; k++) rand_stream(1, 0, 1'b0);
        check_all("restart");
        check("restart_done_once", done_seen - base, 1);

        // reset mid-load, later bytes are ignored until a new start
        do_start(1'b0, 8'h0);
        for (int i = 0; i < 50; i++) send(8'(8'h30 + pattern(i)));
        do_reset();
        check("rst_mid_busy", busy3, 1'b0);
        check("rst_mid_grid_zero", 32'(|grid3), 0);
        send_str("123456789");
        check_all("rst_mid");

        // duplicate clue in the first row
        do_start(1'b0, 8'h0);
        send_str("55");
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
        check("dup_err", err3, 1'b1);
        check("dup_err_cell", ec3, 8'd1);
        check("dup_cell1_zero", g3(1), 9'd0);
`else
        for (int i = 0; i < 79; i++) send(".");
        check("dup_done_valid", gv3, 1'b1);
        check("dup_cell1", g3(1), 9'b000010000);
`endif
        check_all("dup");

        // randomized streams: conflict-free boards and free-running digits with bad bytes
        for (int t = 0; t < 6; t++) begin
            do_start(1'b0, 8'h0);
            for (int k = 0; k < 400 && m_state == 1; k++) rand_stream(1, t % 2, t >= 4);
            check_all($sformatf("rand%0d", t));
        end

        // 16x16 board: top digit 'G' then 255 empties
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        byte4 = "G";
        valid4 = 1'b1;
        @(negedge clk);
        byte4 = "0";
        repeat (255) @(negedge clk);
        check("b4_done_pulse", done4, 1'b1);
        valid4 = 1'b0;
        @(negedge clk);
        check("b4_done_drop", done4, 1'b0);
        check("b4_cell0", grid4[0][0][0][0], 16'h8000);
        check("b4_last_cell", grid4[3][3][3][3], 16'h0);
        check("b4_grid_valid", gv4, 1'b1);
        check("b4_done_count", done4_seen, 1);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("b4_cleared", grid4[0][0][0][0], 16'h0);
        byte4 = "g";
        valid4 = 1'b1;
        @(negedge clk);
        byte4 = "H";
        @(negedge clk);
        valid4 = 1'b0;
        @(negedge clk);
        check("b4_lower_g", grid4[0][0][0][0], 16'h8000);
        check("b4_h_error", err4, 1'b1);
        check("b4_h_err_cell", ec4, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
